// File: rtl/lcd_view_pkg.sv
// lcd_view_pkg: shared LCD command/ASCII constants, FSM states and hex helper
package lcd_view_pkg;
    localparam logic [7:0] FUNC_SET = 8'h38;
    localparam logic [7:0] DISP_ON  = 8'h0C;
    localparam logic [7:0] ENTRY    = 8'h06;
    localparam logic [7:0] CLEAR    = 8'h01;
    localparam logic [7:0] LINE1    = 8'h80;
    localparam logic [7:0] LINE2    = 8'hC0;
    localparam logic [7:0] ASC_R    = 8'h52;
    localparam logic [7:0] ASC_EQ   = 8'h3D;
    localparam logic [7:0] ASC_SP   = 8'h20;
    // Order matters: each stage that finishes advances to the next enum value.
    typedef enum logic [3:0] {
        S_PWRUP, S_INIT, S_CLR, S_SNAP, S_ADDR1, S_LINE1, S_ADDR2, S_LINE2, S_DONE
    } state_t;
    function automatic logic [7:0] hex_to_ascii(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
    endfunction
endpackage

// File: rtl/lcd_reg_view_if.sv
// lcd_reg_view_if: HD44780 parallel bus driven by the register viewer
interface lcd_reg_view_if;
    logic [7:0] data;
    logic       rs;
    logic       rw;
    logic       en;
    logic       on;
    modport master (output data, rs, rw, en, on);
    modport slave  (input data, rs, rw, en, on);
endinterface

// File: rtl/lcd_tick_gen.sv
// lcd_tick_gen: one-clk tick every CLK_DIV clocks, counter cleared by reset
module lcd_tick_gen #(
    parameter int CLK_DIV = 2500
) (
    input  logic clk,
    input  logic rstn,
    output logic tick
);
    localparam int W = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    logic [W-1:0] cnt;
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= cnt == W'(CLK_DIV - 1);
            cnt  <= cnt == W'(CLK_DIV - 1) ? '0 : cnt + 1'b1;
        end
    end
endmodule

// File: rtl/lcd_reg_view.sv
// lcd_reg_view: HD44780 controller paging NUM_CH register values as hex, two per page
module lcd_reg_view
    import lcd_view_pkg::*;
#(
    parameter  int CLK_DIV     = 2500,
    parameter  int PWRUP_TICKS = 400,
    parameter  int CLR_TICKS   = 40,
    parameter  int NUM_CH      = 2,
    parameter  int DATA_W      = 16,
    localparam int NUM_PG      = (NUM_CH + 1) / 2,
    localparam int PG_W        = NUM_PG > 1 ? $clog2(NUM_PG) : 1
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    input  logic                     page_next,
    lcd_reg_view_if.master           lcd,
    output logic [PG_W-1:0]          page,
    output logic                     init_done,
    output logic                     frame_done
);
    localparam int ND   = DATA_W / 4;
    localparam int WMAX = PWRUP_TICKS > CLR_TICKS ? PWRUP_TICKS : CLR_TICKS;
    localparam int WC_W = $clog2(WMAX + 1);
    state_t                   state, state_d;
    logic                     tick, en, en_d, rs, rs_d, pend, pend_d, init_done_d, sending, last;
    logic [7:0]               data, data_d, byte_v, char_v;
    logic [3:0]               idx, idx_d, nib;
    logic [WC_W-1:0]          wcnt, wcnt_d;
    logic [PG_W-1:0]          page_d;
    logic [NUM_CH*DATA_W-1:0] snap, snap_d;
    logic [DATA_W-1:0]        word;
    int                       ch, pos;
    lcd_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (.clk(clk), .rstn(rstn), .tick(tick));
    assign lcd.data = data;
    assign lcd.rs   = rs;
    assign lcd.en   = en;
    assign lcd.rw   = 1'b0;
    assign lcd.on   = 1'b1;
    // Character at column idx of the current line, taken from the frame snapshot.
    always_comb begin
        ch     = 2 * int'(page) + int'(state == S_LINE2);
        pos    = int'(idx);
        word   = DATA_W'(snap >> (ch * DATA_W));
        nib    = 4'(word >> ((ND + 2 - pos) * 4));
        char_v = (ch >= NUM_CH || pos > ND + 2) ? ASC_SP :
                 pos == 0 ? ASC_R : pos == 1 ? 8'(48 + ch) : pos == 2 ? ASC_EQ : hex_to_ascii(nib);
    end
    always_comb begin
        state_d     = state;
        wcnt_d      = wcnt;
        idx_d       = idx;
        en_d        = en;
        data_d      = data;
        rs_d        = rs;
        init_done_d = init_done;
        page_d      = page;
        snap_d      = snap;
        pend_d      = pend | page_next;
        byte_v      = state == S_INIT ? (idx == 4'd0 ? FUNC_SET : idx == 4'd1 ? DISP_ON :
                                         idx == 4'd2 ? ENTRY : CLEAR) :
                      state == S_ADDR1 ? LINE1 : state == S_ADDR2 ? LINE2 : char_v;
        sending     = state inside {S_INIT, S_ADDR1, S_LINE1, S_ADDR2, S_LINE2};
        last        = state inside {S_ADDR1, S_ADDR2} || (state == S_INIT && idx == 4'd3) || idx == 4'd15;
        if (sending && tick) begin
            en_d = !en;
            if (!en) begin
                data_d = byte_v;
                rs_d   = state inside {S_LINE1, S_LINE2};
            end else begin
                idx_d = last ? '0 : idx + 4'd1;
                if (last) state_d = state_t'(state + 4'd1);
            end
        end
        if (state inside {S_PWRUP, S_CLR} && tick) begin
            wcnt_d = wcnt + 1'b1;
            if (wcnt == WC_W'((state == S_PWRUP ? PWRUP_TICKS : CLR_TICKS) - 1)) begin
                wcnt_d      = '0;
                state_d     = state_t'(state + 4'd1);
                init_done_d = init_done | (state == S_CLR);
            end
        end
        // A pulse coinciding with the snapshot is kept for the following frame.
        if (state == S_SNAP) begin
            snap_d  = ch_data;
            pend_d  = page_next;
            state_d = S_ADDR1;
            if (pend) page_d = page == PG_W'(NUM_PG - 1) ? '0 : page + 1'b1;
        end
        if (state == S_DONE) state_d = S_SNAP;
    end
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= S_PWRUP;
            wcnt       <= '0;
            idx        <= '0;
            en         <= 1'b0;
            data       <= '0;
            rs         <= 1'b0;
            init_done  <= 1'b0;
            page       <= '0;
            pend       <= 1'b0;
            snap       <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_d;
            wcnt       <= wcnt_d;
            idx        <= idx_d;
            en         <= en_d;
            data       <= data_d;
            rs         <= rs_d;
            init_done  <= init_done_d;
            page       <= page_d;
            pend       <= pend_d;
            snap       <= snap_d;
            frame_done <= state == S_DONE;
        end
    end
endmodule

// File: tb/tb_lcd_reg_view.sv
// tb_lcd_reg_view: directed checks of init, frame content, snapshot, paging and reset
module tb_lcd_reg_view;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        page_next = 1'b0;
    logic [47:0] ch_data;
    logic        page;
    logic        init_done, frame_done;
    int          compared = 0;
    int          mismatched = 0;
    longint      t_prev = 0, t_now = 0;
    lcd_reg_view_if lcd ();
    always #5 clk = ~clk;
    lcd_reg_view #(
        .CLK_DIV(4), .PWRUP_TICKS(3), .CLR_TICKS(2), .NUM_CH(3), .DATA_W(16)
    ) dut (
        .clk(clk), .rstn(rstn), .ch_data(ch_data), .page_next(page_next),
        .lcd(lcd), .page(page), .init_done(init_done), .frame_done(frame_done)
    );
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic get_byte(input string tag, output logic [7:0] d, output logic r, output int hi);
        int w = 0;
        while (lcd.en !== 1'b1 && w < 3000) begin
            @(negedge clk);
            w++;
        end
        chk({tag, " en rise timeout"}, 128'(w < 3000), 128'(1));
        d  = lcd.data;
        r  = lcd.rs;
        hi = 0;
        while (lcd.en === 1'b1 && hi < 3000) begin
            @(negedge clk);
            hi++;
        end
    endtask
    task automatic get_cmd(input string tag, input logic [7:0] exp);
        logic [7:0] d;
        logic       r;
        int         hi;
        get_byte(tag, d, r, hi);
        chk(tag, d, exp);
        chk({tag, " rs"}, r, 0);
        chk({tag, " en width"}, hi, 4);
    endtask
    task automatic get_line(input string tag, input logic [127:0] exp);
        logic [127:0] line = '0;
        logic [7:0]   d;
        logic         r;
        int           hi;
        logic         rs_ok = 1'b1;
        logic         hi_ok = 1'b1;
        for (int i = 0; i < 16; i++) begin
            get_byte(tag, d, r, hi);
            line  = {line[119:0], d};
            rs_ok = rs_ok & (r === 1'b1);
            hi_ok = hi_ok & (hi == 4);
        end
        chk(tag, line, exp);
        chk({tag, " rs all 1"}, rs_ok, 1);
        chk({tag, " en widths"}, hi_ok, 1);
    endtask
    task automatic run_frame(input logic exp_pg, input logic [127:0] e1, input logic [127:0] e2,
                             input int pulses, input logic set_ff);
        get_cmd("addr1", 8'h80);
        chk("page", page, exp_pg);
        if (set_ff) ch_data[15:0] = 16'hFFFF;
        for (int i = 0; i < pulses; i++) begin
            page_next = 1'b1;
            @(negedge clk);
            page_next = 1'b0;
            @(negedge clk);
        end
        get_line("line1", e1);
        get_cmd("addr2", 8'hC0);
        get_line("line2", e2);
        chk("frame_done at fall", frame_done, 0);
        @(negedge clk);
        chk("frame_done pulse", frame_done, 1);
        t_prev = t_now;
        t_now  = $time;
    endtask
    task automatic init_seq();
        int n = 0;
        rstn = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (lcd.en !== 1'b1 && n < 100);
        chk("pwrup en-low clks", n - 1, 16);
        get_cmd("func_set", 8'h38);
        get_cmd("disp_on", 8'h0C);
        get_cmd("entry", 8'h06);
        get_cmd("clear", 8'h01);
        n = 0;
        while (init_done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("init_done delay", n, 8);
    endtask
    initial begin
        int w = 0;
        ch_data = {16'h5C3E, 16'h00B0, 16'h1A2F};
        repeat (3) @(negedge clk);
        chk("rst en", lcd.en, 0);
        chk("rst data", lcd.data, 0);
        chk("rst rs", lcd.rs, 0);
        chk("rst rw", lcd.rw, 0);
        chk("rst on", lcd.on, 1);
        chk("rst page", page, 0);
        chk("rst init_done", init_done, 0);
        chk("rst frame_done", frame_done, 0);
        init_seq();
        run_frame(1'b0, "R0=1A2F         ", "R1=00B0         ", 0, 1'b0);
        run_frame(1'b0, "R0=1A2F         ", "R1=00B0         ", 0, 1'b1);
        chk("frame period", t_now - t_prev, 2720);
        run_frame(1'b0, "R0=FFFF         ", "R1=00B0         ", 2, 1'b0);
        run_frame(1'b1, "R2=5C3E         ", "                ", 1, 1'b0);
        run_frame(1'b0, "R0=FFFF         ", "R1=00B0         ", 1, 1'b0);
        while (lcd.en !== 1'b1 && w < 3000) begin
            @(negedge clk);
            w++;
        end
        chk("pre-reset en", lcd.en, 1);
        chk("pre-reset page", page, 1);
        chk("pre-reset data", lcd.data, 8'h80);
        rstn = 1'b0;
        @(negedge clk);
        chk("mid-byte rst en", lcd.en, 0);
        chk("mid-byte rst data", lcd.data, 0);
        chk("mid-byte rst init_done", init_done, 0);
        chk("mid-byte rst page", page, 0);
        chk("mid-byte rst rs", lcd.rs, 0);
        repeat (2) @(negedge clk);
        init_seq();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/lcd_reg_view.md
# lcd_reg_view

Parametrised HD44780 character-LCD controller that shows NUM_CH CPU register values as hex on a 16x2 display, two registers per page. It is the board-level debug display for the CPU: the top level wires register values in, and the block runs power-up init and then refreshes frames continuously. A page-advance input steps through the register pages. Each frame is drawn from a coherent snapshot of the register values.

## Interface
- CLK_DIV, 2500: clk cycles per LCD tick; 50 us at 50 MHz.
- PWRUP_TICKS, 400: ticks to wait after reset before the first command.
- CLR_TICKS, 40: extra ticks to wait after the clear command 0x01.
- NUM_CH, 2: number of registers displayed; 1..10.
- DATA_W, 16: register width; a multiple of 4, range 4..52.
- clk  in  1  system clock; one clock domain only.
- rstn  in  1  synchronous, active-low reset.
- ch_data  in  NUM_CH*DATA_W  flat register bus; channel i occupies bits [i*DATA_W +: DATA_W].
- page_next  in  1  one-clock pulse requesting the next page.
- LCD_DATA  out  8  LCD data bus.
- LCD_RS  out  1  0 = command, 1 = character.
- LCD_RW  out  1  tied 0 (write only).
- LCD_EN  out  1  LCD enable strobe.
- LCD_ON  out  1  tied 1.
- page  out  max(1,$clog2(ceil(NUM_CH/2)))  currently displayed page.
- init_done  out  1  high once initialisation is complete; stays high until reset.
- frame_done  out  1  one-clock pulse at the end of every frame.

## Operation
- Reset values: LCD_DATA=0, LCD_RS=0, LCD_EN=0, LCD_RW=0, LCD_ON=1, page=0, init_done=0, frame_done=0.
- Tick: a one-clk pulse every CLK_DIV clocks. The tick counter is cleared by reset. All state machine steps advance only on a tick.
- Byte transfer: 2 ticks.
  - First tick: LCD_DATA and LCD_RS are loaded and LCD_EN goes to 1.
  - Second tick: LCD_EN goes to 0.
  - LCD_DATA and LCD_RS hold their values until the next byte is loaded.
- FSM states:
  - PWRUP: wait PWRUP_TICKS ticks, then go to INIT.
  - INIT: send commands 0x38, 0x0C, 0x06, 0x01 in that order. After 0x01, wait CLR_TICKS ticks, set init_done, then go to FRAME.
  - FRAME: sub-steps are SNAP, ADDR1 (send 0x80), LINE1 (16 characters), ADDR2 (send 0xC0), LINE2 (16 characters), DONE.
  - DONE pulses frame_done and returns to SNAP.
- SNAP (zero ticks, a single clk):
  - Latch all of ch_data into a snapshot register.
  - Apply any pending page advance: page+1, wrapping from the last page to 0.
  - Clear the pending flag.
- Line layout for channel c:
  - 'R', then ASCII digit c, then '=', then DATA_W/4 upper-case hex digits MSB first.
  - Pad with 0x20 to 16 characters.
  - Line 1 shows channel 2*page; line 2 shows channel 2*page+1.
  - A line whose channel is >= NUM_CH is 16 spaces.
- page_next sets a sticky pending flag. Several pulses within one frame produce one advance. A pulse on the same clk as SNAP counts toward the following frame.
- A page advance is never applied mid-frame.
- ch_data changes between SNAPs never appear in the current frame.
- Reset asserted at any point, including while LCD_EN=1, forces all outputs to their reset values on the next clk and restarts from PWRUP.

## Timing
- First tick arrives CLK_DIV clks after rstn is sampled high.
- First LCD_EN rise occurs on tick PWRUP_TICKS+1.
- Each LCD_EN high pulse lasts exactly CLK_DIV clks. Each byte occupies 2*CLK_DIV clks.
- Init length: PWRUP_TICKS + 8 + CLR_TICKS ticks.
- Frame length: 34 bytes = 68 ticks. frame_done then pulses 1 clk after the last LCD_EN fall.
- Data to display latency: at most 2 frames, i.e. 136 ticks plus 1 clk.

## Structure
- Shared package lcd_view_pkg holds:
  - LCD command constants: FUNC_SET 0x38, DISP_ON 0x0C, ENTRY 0x06, CLEAR 0x01, LINE1 0x80, LINE2 0xC0.
  - ASCII constants for 'R', '=', space.
  - A hex_to_ascii(4-bit) function.
  - The FSM state enum.
- Sub-module lcd_tick_gen (parameter CLK_DIV) produces the tick pulse; it is reused by the other LCD blocks.

## Test plan
All scenarios use CLK_DIV=4, PWRUP_TICKS=3, CLR_TICKS=2, NUM_CH=3, DATA_W=16.
- Init: release rstn.
  - LCD_EN stays 0 for 16 clks.
  - Then RS=0 bytes 0x38, 0x0C, 0x06, 0x01 follow, each with LCD_EN high exactly 4 clks.
  - init_done rises 8 clks after the last LCD_EN fall.
- Frame content: ch0=0x1A2F, ch1=0x00B0.
  - Expect 0x80, then "R0=1A2F" plus 9×0x20 with RS=1.
  - Then 0xC0, then "R1=00B0" plus 9 spaces.
  - frame_done pulses once per 272 clks.
- Snapshot: change ch0 to 0xFFFF during LINE1.
  - The current frame still shows "1A2F".
  - The next frame shows "FFFF".
- Page and blank: pulse page_next twice within one frame.
  - Next frame: page=1, line 1 shows "R2=..." and line 2 is 16 spaces.
  - One more pulse returns page to 0.
- Reset mid-byte: assert rstn=0 while LCD_EN=1.
  - On the next clk LCD_EN=0, LCD_DATA=0, init_done=0, page=0.
  - On release, the full init sequence repeats.
